serial_sub_ctrl: RTL

//   Bit-serial N-bit subtraction controller: computes diff = a - b, LSB first, through one
//   1-bit full-subtract cell over WIDTH clock cycles. Owns the operand shift registers,

---
 rtl/serial_sub_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: diff = a - b (mod 2^WIDTH), one bit per
// clock, LSB first, through a single full-subtract cell. Owns the operand
// shift registers, borrow flop, bit counter and start/busy/done handshake.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int                 CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Only WIDTH-1 partial result bits need storage: the last bit comes
  // straight from the cell on the final SHIFT cycle.
  logic [WIDTH-2:0] r_sh_q, r_sh_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             zero_q, zero_d;

  logic             d_bit;
  logic             bout;
  logic [WIDTH-1:0] r_full;

  // Full-subtract cell on the current operand LSBs and running borrow.
  always_comb begin
    d_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
    bout  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);
  end

  // Partial result with this cycle's difference bit inserted at the top;
  // on the last SHIFT cycle this is the complete result.
  assign r_full = {d_bit, r_sh_q};

  // Next-state and datapath update: load on accept, shift while running,
  // latch results on leaving SHIFT.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          r_sh_d  = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        r_sh_d = r_full[WIDTH-1:1];
        brw_d  = bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          diff_d  = r_full;
          bo_d    = bout;
          zero_d  = (r_full == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shift registers, borrow, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      r_sh_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      r_sh_q <= r_sh_d;
      brw_q  <= brw_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bo_q   <= bo_d;
      zero_q <= zero_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;
  assign zero       = zero_q;

endmodule
